// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I immediate generator behind a two-entry skid buffer.
// Optional feature: define IMMGEN_ZICSR_EN to decode CSRRWI/CSRRSI/CSRRCI zimm as type Z.
module imm_gen_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef enum logic [2:0] {
        T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
        T_U    = 3'd4, T_J = 3'd5, T_Z = 3'd6
    } imm_type_t;

    state_t          state, state_nxt;
    logic            accept, fire, load_out, load_skid, skid_to_out;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm, skid_imm;
    logic [2:0]      dec_type, skid_type;
    logic            dec_illegal, skid_illegal;

    always_comb begin
        imm32       = '0;
        dec_type    = T_NONE;
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: begin
                    imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_type = T_I;
                end
                7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                    if (in_instr[14]) begin
                        imm32    = {27'b0, in_instr[19:15]};
                        dec_type = T_Z;
                    end else begin
                        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                        dec_type = T_I;
                    end
`else
                    imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_type = T_I;
`endif
                end
                7'b0100011: begin
                    imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                    dec_type = T_S;
                end
                7'b1100011: begin
                    imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
                    dec_type = T_B;
                end
                7'b0110111, 7'b0010111: begin
                    imm32    = {in_instr[31:12], 12'b0};
                    dec_type = T_U;
                end
                7'b1101111: begin
                    imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
                    dec_type = T_J;
                end
                7'b0110011, 7'b0001111: dec_type = T_NONE;
                default:                dec_illegal = 1'b1;
            endcase
        end
        // Z immediates have bit 31 clear, so sign extension leaves them zero-extended
        dec_imm        = {XLEN{imm32[31]}};
        dec_imm[31:0]  = imm32;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !fire)      state_nxt = FULL;
                    else if (!accept && fire) state_nxt = EMPTY;
                end
                FULL:    if (fire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready and out_valid depend only on the state register
    always_comb begin
        out_valid   = (state != EMPTY);
        in_ready    = (state != FULL);
        accept      = in_valid && in_ready;
        fire        = out_valid && out_ready;
        load_out    = accept && !flush && ((state == EMPTY) || fire);
        load_skid   = accept && !flush && (state == ONE) && !fire;
        skid_to_out = fire && !flush && (state == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm      <= '0;
            out_type     <= '0;
            out_illegal  <= 1'b0;
            skid_imm     <= '0;
            skid_type    <= '0;
            skid_illegal <= 1'b0;
        end else begin
            if (load_out) begin
                out_imm     <= dec_imm;
                out_type    <= dec_type;
                out_illegal <= dec_illegal;
            end else if (skid_to_out) begin
                out_imm     <= skid_imm;
                out_type    <= skid_type;
                out_illegal <= skid_illegal;
            end
            if (load_skid) begin
                skid_imm     <= dec_imm;
                skid_type    <= dec_type;
                skid_illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed scoreboard bench for imm_gen_pipe (XLEN=32).
// CSR zimm expectation follows IMMGEN_ZICSR_EN when the macro is defined.
module tb_imm_gen_pipe;

    localparam int unsigned XLEN = 32;
    localparam logic [2:0] TN = 3'd0, TI = 3'd1, TS = 3'd2, TB = 3'd3, TU = 3'd4, TJ = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_instr = '0;
    logic            in_ready, out_valid, out_illegal;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;

    exp_t sb[$];
    exp_t pend;
    int   errors = 0;
    int   checks = 0;
    bit   acc;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes at negedge: pop delivered output first, then push accepted input.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready && !flush;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("imm", 64'(out_imm), 64'(e.imm));
                chk("type", 64'(out_type), 64'(e.typ));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
            end
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [XLEN-1:0] imm,
                         input logic [2:0] typ, input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        pend.imm = imm;
        pend.typ = typ;
        pend.ill = ill;
    endtask

    task automatic wait_acc();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] imm,
                        input logic [2:0] typ, input logic ill);
        drive(instr, imm, typ, ill);
        wait_acc();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_type", 64'(out_type), 64'd0);
        chk("rst_ill", 64'(out_illegal), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // streaming, one per cycle
        out_ready = 1'b1;
        send(32'hFFF00093, 32'hFFFFFFFF, TI, 1'b0);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_imm", 64'(out_imm), 64'hFFFFFFFF);
        send(32'h00208863, 32'd16,       TB, 1'b0);
        send(32'h8000006F, 32'hFFF00000, TJ, 1'b0);
        send(32'h12345037, 32'h12345000, TU, 1'b0);
        send(32'hFE112E23, 32'hFFFFFFFC, TS, 1'b0);
        send(32'h00412083, 32'd4,        TI, 1'b0);
        send(32'hFFC080E7, 32'hFFFFFFFC, TI, 1'b0);
        send(32'hFFFFF117, 32'hFFFFF000, TU, 1'b0);
        send(32'h0080006F, 32'd8,        TJ, 1'b0);
        send(32'h002081B3, 32'd0,        TN, 1'b0);
        send(32'h0FF0000F, 32'd0,        TN, 1'b0);
        send(32'h0000007F, 32'd0,        TN, 1'b1);
        send(32'h00000010, 32'd0,        TN, 1'b1);
        send(32'h34009073, 32'h340,      TI, 1'b0);
`ifdef IMMGEN_ZICSR_EN
        send(32'h3400D073, 32'd1,        3'd6, 1'b0);
`else
        send(32'h3400D073, 32'h340,      TI, 1'b0);
`endif
        chk("stream_ready", 64'(in_ready), 64'd1);
        drain();

        // back-pressure: OUT, SKID, then stall
        out_ready = 1'b0;
        drive(32'hFFF00093, 32'hFFFFFFFF, TI, 1'b0);
        cycle();
        drive(32'h00208863, 32'd16, TB, 1'b0);
        cycle();
        drive(32'h8000006F, 32'hFFF00000, TJ, 1'b0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("hold_imm0", 64'(out_imm), 64'hFFFFFFFF);
        cycle();
        chk("stall_noacc", 64'(acc), 64'd0);
        chk("hold_imm1", 64'(out_imm), 64'hFFFFFFFF);
        chk("hold_type", 64'(out_type), 64'(TI));
        out_ready = 1'b1;
        wait_acc();
        drain();

        // flush from FULL with a pending input
        out_ready = 1'b0;
        drive(32'h12345037, 32'h12345000, TU, 1'b0);
        cycle();
        drive(32'hFE112E23, 32'hFFFFFFFC, TS, 1'b0);
        cycle();
        drive(32'h0080006F, 32'd8, TJ, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();

        // flush in ONE: output handshake delivered, same-cycle input dropped
        send(32'h00412083, 32'd4, TI, 1'b0);
        drive(32'hFFFFF117, 32'hFFFFF000, TU, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1_valid", 64'(out_valid), 64'd0);
        repeat (3) cycle();

        // asynchronous reset while FULL
        out_ready = 1'b0;
        drive(32'hFFF00093, 32'hFFFFFFFF, TI, 1'b0);
        cycle();
        drive(32'h0000007F, 32'd0, TN, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_imm", 64'(out_imm), 64'd0);
        chk("arst_type", 64'(out_type), 64'd0);
        chk("arst_ill", 64'(out_illegal), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        out_ready = 1'b1;
        send(32'h12345037, 32'h12345000, TU, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
